// File: rtl/m2_block_scheduler_pkg.sv
// Shared types and constants for the milestone-2 IDCT block scheduler.
package m2_block_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_FS,
    S_LEAD_CT,
    S_MEGA_A,
    S_MEGA_B,
    S_OUT_CS,
    S_OUT_WS,
    S_DONE
  } m2_state_e;

  localparam logic [1:0] PLANE_Y = 2'd0;
  localparam logic [1:0] PLANE_U = 2'd1;
  localparam logic [1:0] PLANE_V = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_FS   = 2'd1;
  localparam logic [1:0] OWN_WS   = 2'd2;

endpackage

// File: rtl/m2_block_scheduler_if.sv
// Handshake, block-pointer and SRAM bus between the scheduler, the milestone FSM and the sub-blocks.
interface m2_block_scheduler_if;
  logic        M2_start, M2_done;
  logic        FS_start, CT_start, CS_start, WS_start;
  logic        FS_done, CT_done, CS_done, WS_done;
  logic [1:0]  fs_plane, ws_plane;
  logic [5:0]  fs_col, ws_col;
  logic [4:0]  fs_row, ws_row;
  logic [17:0] FS_SRAM_address, WS_SRAM_address, SRAM_address;
  logic        WS_SRAM_we_n, SRAM_we_n;
  logic [15:0] WS_SRAM_write_data, SRAM_write_data;
  logic [1:0]  sram_owner;

  modport master (
    input  M2_start, FS_done, CT_done, CS_done, WS_done,
           FS_SRAM_address, WS_SRAM_address, WS_SRAM_we_n, WS_SRAM_write_data,
    output M2_done, FS_start, CT_start, CS_start, WS_start,
           fs_plane, fs_col, fs_row, ws_plane, ws_col, ws_row,
           SRAM_address, SRAM_we_n, SRAM_write_data, sram_owner
  );

  modport slave (
    output M2_start, FS_done, CT_done, CS_done, WS_done,
           FS_SRAM_address, WS_SRAM_address, WS_SRAM_we_n, WS_SRAM_write_data,
    input  M2_done, FS_start, CT_start, CS_start, WS_start,
           fs_plane, fs_col, fs_row, ws_plane, ws_col, ws_row,
           SRAM_address, SRAM_we_n, SRAM_write_data, sram_owner
  );
endinterface

// File: rtl/m2_block_pointer.sv
// Plane/row/column walker over Y, U, V blocks; column fastest, wraps V-last back to Y 0,0.
module m2_block_pointer
  import m2_block_scheduler_pkg::*;
#(
  parameter int Y_COLS  = 40,
  parameter int Y_ROWS  = 30,
  parameter int UV_COLS = 20,
  parameter int UV_ROWS = 30
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       advance_i,
  output logic [1:0] plane_o,
  output logic [5:0] col_o,
  output logic [4:0] row_o,
  output logic       last_o
);

  localparam logic [5:0] Y_CMAX  = 6'(Y_COLS - 1);
  localparam logic [4:0] Y_RMAX  = 5'(Y_ROWS - 1);
  localparam logic [5:0] UV_CMAX = 6'(UV_COLS - 1);
  localparam logic [4:0] UV_RMAX = 5'(UV_ROWS - 1);

  logic [1:0] plane_q, plane_d;
  logic [5:0] col_q, col_d, cmax;
  logic [4:0] row_q, row_d, rmax;

  always_comb begin
    cmax    = (plane_q == PLANE_Y) ? Y_CMAX : UV_CMAX;
    rmax    = (plane_q == PLANE_Y) ? Y_RMAX : UV_RMAX;
    plane_d = plane_q;
    col_d   = col_q;
    row_d   = row_q;
    if (advance_i) begin
      if (col_q != cmax) begin
        col_d = col_q + 6'd1;
      end else begin
        col_d = '0;
        if (row_q != rmax) begin
          row_d = row_q + 5'd1;
        end else begin
          row_d   = '0;
          plane_d = (plane_q == PLANE_V) ? PLANE_Y : plane_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      plane_q <= PLANE_Y;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      plane_q <= plane_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  assign plane_o = plane_q;
  assign col_o   = col_q;
  assign row_o   = row_q;
  assign last_o  = (plane_q == PLANE_V) && (col_q == UV_CMAX) && (row_q == UV_RMAX);

endmodule

// File: rtl/m2_block_scheduler.sv
// Milestone-2 sequencer: overlaps FS/CT/CS/WS across all Y/U/V blocks and arbitrates the SRAM port.
module m2_block_scheduler
  import m2_block_scheduler_pkg::*;
#(
  parameter int Y_COLS  = 40,
  parameter int Y_ROWS  = 30,
  parameter int UV_COLS = 20,
  parameter int UV_ROWS = 30
) (
  input  logic                CLOCK_50_I,
  input  logic                Resetn,
  m2_block_scheduler_if.master bus
);

  localparam int         N     = Y_COLS * Y_ROWS + 2 * UV_COLS * UV_ROWS;
  localparam logic [11:0] N_CNT = 12'(N);

  m2_state_e   state_q, state_d;
  logic        first_q;
  logic        flag0_q, flag0_d, flag1_q, flag1_d;
  logic [11:0] fetch_cnt_q, fetch_cnt_d;
  logic        fs_start_q, ct_start_q, cs_start_q, ws_start_q, m2_done_q;
  logic        fs_ok, ct_ok, cs_ok, ws_ok, hit0, hit1, fs_adv, ws_adv, entering;
  logic        fs_last, ws_last;
  logic [1:0]  fs_plane, ws_plane;
  logic [5:0]  fs_col, ws_col;
  logic [4:0]  fs_row, ws_row;

  // Dones landing in a state's first cycle belong to no running sub-block.
  assign fs_ok = bus.FS_done & ~first_q;
  assign ct_ok = bus.CT_done & ~first_q;
  assign cs_ok = bus.CS_done & ~first_q;
  assign ws_ok = bus.WS_done & ~first_q;

  always_comb begin
    state_d     = state_q;
    flag0_d     = flag0_q;
    flag1_d     = flag1_q;
    fetch_cnt_d = fetch_cnt_q;
    fs_adv      = 1'b0;
    ws_adv      = 1'b0;
    hit0        = 1'b0;
    hit1        = 1'b0;
    unique case (state_q)
      S_IDLE: if (bus.M2_start) begin
        state_d     = S_LEAD_FS;
        fetch_cnt_d = '0;
      end
      S_LEAD_FS: if (fs_ok) begin
        fs_adv  = 1'b1;
        state_d = S_LEAD_CT;
      end
      S_LEAD_CT: if (ct_ok) state_d = (N_CNT > 12'd1) ? S_MEGA_A : S_OUT_CS;
      S_MEGA_A: begin
        // flag0 tracks CS, flag1 tracks FS
        hit0   = flag0_q | cs_ok;
        hit1   = flag1_q | fs_ok;
        fs_adv = fs_ok & ~flag1_q;
        if (hit0 && hit1) begin
          state_d = S_MEGA_B;
          flag0_d = 1'b0;
          flag1_d = 1'b0;
        end else begin
          flag0_d = hit0;
          flag1_d = hit1;
        end
      end
      S_MEGA_B: begin
        // flag0 tracks CT, flag1 tracks WS
        hit0   = flag0_q | ct_ok;
        hit1   = flag1_q | ws_ok;
        ws_adv = ws_ok & ~flag1_q;
        if (hit0 && hit1) begin
          state_d = (fetch_cnt_q < N_CNT) ? S_MEGA_A : S_OUT_CS;
          flag0_d = 1'b0;
          flag1_d = 1'b0;
        end else begin
          flag0_d = hit0;
          flag1_d = hit1;
        end
      end
      S_OUT_CS: if (cs_ok) state_d = S_OUT_WS;
      S_OUT_WS: if (ws_ok) begin
        ws_adv  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (fs_adv) fetch_cnt_d = fetch_cnt_q + 12'd1;
  end

  assign entering = (state_d != state_q);

  always_ff @(posedge CLOCK_50_I) begin
    if (!Resetn) begin
      state_q     <= S_IDLE;
      first_q     <= 1'b0;
      flag0_q     <= 1'b0;
      flag1_q     <= 1'b0;
      fetch_cnt_q <= '0;
      fs_start_q  <= 1'b0;
      ct_start_q  <= 1'b0;
      cs_start_q  <= 1'b0;
      ws_start_q  <= 1'b0;
      m2_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      first_q     <= entering;
      flag0_q     <= flag0_d;
      flag1_q     <= flag1_d;
      fetch_cnt_q <= fetch_cnt_d;
      fs_start_q  <= entering && (state_d == S_LEAD_FS || state_d == S_MEGA_A);
      ct_start_q  <= entering && (state_d == S_LEAD_CT || state_d == S_MEGA_B);
      cs_start_q  <= entering && (state_d == S_MEGA_A  || state_d == S_OUT_CS);
      ws_start_q  <= entering && (state_d == S_MEGA_B  || state_d == S_OUT_WS);
      m2_done_q   <= entering && (state_d == S_DONE);
    end
  end

  m2_block_pointer #(.Y_COLS(Y_COLS), .Y_ROWS(Y_ROWS), .UV_COLS(UV_COLS), .UV_ROWS(UV_ROWS))
    u_fetch_ptr (.clk_i(CLOCK_50_I), .rst_ni(Resetn), .advance_i(fs_adv),
                 .plane_o(fs_plane), .col_o(fs_col), .row_o(fs_row), .last_o(fs_last));

  m2_block_pointer #(.Y_COLS(Y_COLS), .Y_ROWS(Y_ROWS), .UV_COLS(UV_COLS), .UV_ROWS(UV_ROWS))
    u_write_ptr (.clk_i(CLOCK_50_I), .rst_ni(Resetn), .advance_i(ws_adv),
                 .plane_o(ws_plane), .col_o(ws_col), .row_o(ws_row), .last_o(ws_last));

  always_comb begin
    bus.sram_owner      = OWN_NONE;
    bus.SRAM_address    = '0;
    bus.SRAM_we_n       = 1'b1;
    bus.SRAM_write_data = '0;
    if (state_q == S_LEAD_FS || state_q == S_MEGA_A) begin
      bus.sram_owner   = OWN_FS;
      bus.SRAM_address = bus.FS_SRAM_address;
    end else if (state_q == S_MEGA_B || state_q == S_OUT_WS) begin
      bus.sram_owner      = OWN_WS;
      bus.SRAM_address    = bus.WS_SRAM_address;
      bus.SRAM_we_n       = bus.WS_SRAM_we_n;
      bus.SRAM_write_data = bus.WS_SRAM_write_data;
    end
  end

  assign bus.FS_start = fs_start_q;
  assign bus.CT_start = ct_start_q;
  assign bus.CS_start = cs_start_q;
  assign bus.WS_start = ws_start_q;
  assign bus.M2_done  = m2_done_q;
  assign bus.fs_plane = fs_plane;
  assign bus.fs_col   = fs_col;
  assign bus.fs_row   = fs_row;
  assign bus.ws_plane = ws_plane;
  assign bus.ws_col   = ws_col;
  assign bus.ws_row   = ws_row;

  // Pointer position and fetch count must stay in lockstep across the frame.
  a_fetch_last: assert property (@(posedge CLOCK_50_I) disable iff (!Resetn)
    (fs_adv && fs_last) |-> (fetch_cnt_q == N_CNT - 12'd1));
  a_write_last: assert property (@(posedge CLOCK_50_I) disable iff (!Resetn)
    (state_q == S_OUT_WS) |-> ws_last);

endmodule
